// File: rtl/lpddr2_req_bridge_if.sv
// Core/LPDDR2 request bundle for lpddr2_req_bridge.
// master = core plus memory model side, slave = the bridge.
interface lpddr2_req_bridge_if #(
    parameter int ADDR_W = 27
);
    logic              core_start;
    logic              core_rd;
    logic              core_wr;
    logic [29:0]       core_addr;
    logic [31:0]       core_wdata;
    logic              abort;
    logic [31:0]       core_rdata;
    logic              core_busy;
    logic              core_done;
    logic              core_fault;
    logic [ADDR_W-1:0] lpddr2_address;
    logic [31:0]       lpddr2_write_data;
    logic [31:0]       lpddr2_read_data;
    logic              lpddr2_rreq;
    logic              lpddr2_wreq;

    modport master (
        output core_start, core_rd, core_wr, core_addr, core_wdata, abort,
        output lpddr2_read_data,
        input  core_rdata, core_busy, core_done, core_fault,
        input  lpddr2_address, lpddr2_write_data, lpddr2_rreq, lpddr2_wreq
    );

    modport slave (
        input  core_start, core_rd, core_wr, core_addr, core_wdata, abort,
        input  lpddr2_read_data,
        output core_rdata, core_busy, core_done, core_fault,
        output lpddr2_address, lpddr2_write_data, lpddr2_rreq, lpddr2_wreq
    );
endinterface

// File: rtl/lpddr2_req_bridge.sv
// Single-access sequencer from the CPU memory stage to the LPDDR2 port.
// Fixed-latency request levels, read capture, fault and abort handling.
module lpddr2_req_bridge #(
    parameter int ADDR_W = 27,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    lpddr2_req_bridge_if.slave bus
);
    localparam int LMAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;
    localparam logic [CW-1:0] RD_CNT = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WR_CNT = CW'(WR_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rreq_q, rreq_d;
    logic              wreq_q, wreq_d;
    logic              fault_q, fault_d;
    logic              addr_oob;

    // Any bit above the LPDDR2 word address makes the request a fault.
    assign addr_oob = (bus.core_addr >> ADDR_W) != '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rreq_d  = rreq_q;
        wreq_d  = wreq_q;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.core_start && !bus.abort) begin
                    if (bus.core_rd && bus.core_wr) begin
                        fault_d = 1'b1;
                    end else if (addr_oob) begin
                        fault_d = 1'b1;
                    end else if (!bus.core_rd && !bus.core_wr) begin
                        state_d = DONE;
                    end else if (bus.core_rd) begin
                        addr_d  = bus.core_addr[ADDR_W-1:0];
                        rreq_d  = 1'b1;
                        cnt_d   = RD_CNT;
                        state_d = RD_WAIT;
                    end else begin
                        addr_d  = bus.core_addr[ADDR_W-1:0];
                        wdata_d = bus.core_wdata;
                        wreq_d  = 1'b1;
                        cnt_d   = WR_CNT;
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.abort) begin
                    rreq_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = bus.lpddr2_read_data;
                    rreq_d  = 1'b0;
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                if (bus.abort) begin
                    wreq_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    wreq_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
            fault_q <= fault_d;
        end
    end

    assign bus.core_rdata        = rdata_q;
    assign bus.core_busy         = (state_q != IDLE);
    assign bus.core_done         = (state_q == DONE);
    assign bus.core_fault        = fault_q;
    assign bus.lpddr2_address    = addr_q;
    assign bus.lpddr2_write_data = wdata_q;
    assign bus.lpddr2_rreq       = rreq_q;
    assign bus.lpddr2_wreq       = wreq_q;
endmodule

// File: tb/tb_lpddr2_req_bridge.sv
// Self-checking bench for lpddr2_req_bridge: directed scenarios, then
// random transactions checked against a transaction-level model.
module tb_lpddr2_req_bridge;
    localparam int AW = 27;
    localparam int RL = 4;
    localparam int WL = 2;
    localparam logic [31:0] LIMIT = 32'd1 << AW;

    typedef enum int { K_FAULT, K_NOP, K_RD, K_WR } kind_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lpddr2_req_bridge_if #(.ADDR_W(AW)) bus ();

    lpddr2_req_bridge #(
        .ADDR_W(AW),
        .RD_LAT(RL),
        .WR_LAT(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model of the architecturally visible latched values.
    logic [31:0]   m_rdata;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;

    logic          r_rd, r_wr, r_junk;
    logic [29:0]   r_a;
    logic [31:0]   r_wd;
    int            r_ab, r_lat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit busy, input bit done,
                           input bit rreq, input bit wreq, input bit fault);
        chk({tag, ".busy"},  32'(bus.core_busy),   32'(busy));
        chk({tag, ".done"},  32'(bus.core_done),   32'(done));
        chk({tag, ".rreq"},  32'(bus.lpddr2_rreq), 32'(rreq));
        chk({tag, ".wreq"},  32'(bus.lpddr2_wreq), 32'(wreq));
        chk({tag, ".fault"}, 32'(bus.core_fault),  32'(fault));
        chk({tag, ".addr"},  32'(bus.lpddr2_address), 32'(m_addr));
        chk({tag, ".wdata"}, bus.lpddr2_write_data, m_wdata);
        chk({tag, ".rdata"}, bus.core_rdata, m_rdata);
    endtask

    function automatic kind_e classify(input bit rd, input bit wr,
                                       input logic [29:0] a);
        if (rd && wr)               return K_FAULT;
        if ({2'b00, a} >= LIMIT)    return K_FAULT;
        if (!rd && !wr)             return K_NOP;
        return rd ? K_RD : K_WR;
    endfunction

    // One transaction starting at a negedge in IDLE. abort_at: cycle
    // (0 = with start, lat+1 = DONE cycle) abort is held, -1 for none.
    task automatic xact(input string tag, input bit rd, input bit wr,
                        input logic [29:0] a, input logic [31:0] wd,
                        input int abort_at, input bit junk,
                        input bit fix, input logic [31:0] fval);
        kind_e k;
        int lat;
        logic [31:0] last_rd;
        k = classify(rd, wr, a);
        lat = (k == K_RD) ? RL : (k == K_WR) ? WL : 0;
        last_rd = '0;
        chk_out({tag, ".pre"}, 0, 0, 0, 0, 0);
        bus.core_start = 1'b1;
        bus.core_rd = rd;
        bus.core_wr = wr;
        bus.core_addr = a;
        bus.core_wdata = wd;
        bus.abort = (abort_at == 0);
        bus.lpddr2_read_data = $urandom;
        @(negedge clk);
        bus.core_start = 1'b0;
        bus.abort = 1'b0;
        if (abort_at == 0) begin
            chk_out({tag, ".ign"}, 0, 0, 0, 0, 0);
            return;
        end
        if (k == K_FAULT) begin
            chk_out({tag, ".flt"}, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk_out({tag, ".fltend"}, 0, 0, 0, 0, 0);
            return;
        end
        if (k != K_NOP) m_addr = a[AW-1:0];
        if (k == K_WR)  m_wdata = wd;
        for (int c = 1; c <= lat; c++) begin
            chk_out({tag, ".wait"}, 1, 0, k == K_RD, k == K_WR, 0);
            if (junk) begin
                bus.core_start = 1'b1;
                bus.core_rd = 1'($urandom);
                bus.core_wr = 1'($urandom);
                bus.core_addr = 30'($urandom);
                bus.core_wdata = $urandom;
            end
            last_rd = fix && c == lat ? fval : $urandom;
            bus.lpddr2_read_data = last_rd;
            if (c == abort_at) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                bus.core_start = 1'b0;
                chk_out({tag, ".abort"}, 0, 0, 0, 0, 0);
                return;
            end
            @(negedge clk);
        end
        if (k == K_RD) m_rdata = last_rd;
        chk_out({tag, ".done"}, 1, 1, 0, 0, 0);
        bus.abort = (abort_at == lat + 1);
        if (junk) bus.core_start = 1'b1;
        bus.lpddr2_read_data = $urandom;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.core_start = 1'b0;
    endtask

    initial begin
        bus.core_start = 1'b0;
        bus.core_rd = 1'b0;
        bus.core_wr = 1'b0;
        bus.core_addr = '0;
        bus.core_wdata = '0;
        bus.abort = 1'b0;
        bus.lpddr2_read_data = '0;
        m_rdata = '0;
        m_addr = '0;
        m_wdata = '0;

        @(negedge clk);
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xact("rd123", 1, 0, 30'h0000123, '0, -1, 0, 1, 32'hDEADBEEF);
        chk("rd123.val", bus.core_rdata, 32'hDEADBEEF);
        chk("rd123.adr", 32'(bus.lpddr2_address), 32'h123);

        xact("wr10", 0, 1, 30'h10, 32'hCAFEF00D, -1, 0, 0, '0);
        chk("wr10.wd", bus.lpddr2_write_data, 32'hCAFEF00D);
        chk("wr10.rd", bus.core_rdata, 32'hDEADBEEF);

        xact("rdwr", 1, 1, 30'h40, '0, -1, 0, 0, '0);
        xact("oob", 1, 0, 30'h0800_0000, '0, -1, 0, 0, '0);
        xact("nop", 0, 0, 30'h7, '0, -1, 0, 0, '0);

        xact("rdabt", 1, 0, 30'h200, '0, 2, 0, 0, '0);
        chk("rdabt.rd", bus.core_rdata, 32'hDEADBEEF);

        xact("busy", 1, 0, 30'h123, '0, -1, 1, 0, '0);
        chk("busy.adr", 32'(bus.lpddr2_address), 32'h123);

        xact("abtidle", 1, 0, 30'h321, '0, 0, 0, 0, '0);
        xact("abtdone", 0, 1, 30'h44, 32'h1234_5678, WL + 1, 0, 0, '0);

        // Reset between edges while a write is in flight.
        bus.core_start = 1'b1;
        bus.core_rd = 1'b0;
        bus.core_wr = 1'b1;
        bus.core_addr = 30'h99;
        bus.core_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.core_start = 1'b0;
        chk("rstw.wreq", 32'(bus.lpddr2_wreq), 32'd1);
        #2 rst = 1'b1;
        #1;
        m_rdata = '0;
        m_addr = '0;
        m_wdata = '0;
        chk_out("rstw", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xact("rd2", 1, 0, 30'h0000123, '0, -1, 0, 1, 32'hDEADBEEF);
        chk("rd2.val", bus.core_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 200; i++) begin
            r_rd = 1'($urandom);
            r_wr = 1'($urandom);
            if ($urandom_range(0, 7) == 0) r_a = 30'($urandom);
            else r_a = 30'($urandom) & 30'(LIMIT - 1);
            r_wd = $urandom;
            r_lat = r_rd ? RL : WL;
            r_ab = ($urandom_range(0, 9) < 2) ? $urandom_range(0, r_lat + 1) : -1;
            r_junk = 1'($urandom);
            xact("rnd", r_rd, r_wr, r_a, r_wd, r_ab, r_junk, 0, '0);
        end
        chk_out("final", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lpddr2_req_bridge.md
Name: lpddr2_req_bridge

Overview:
- Sequencer between the CPU memory stage and the LPDDR2 port.
- Accepts one word-addressed read or write from the core.
- Drives lpddr2_rreq/lpddr2_wreq for a fixed, parameterised latency, captures read data, then pulses a completion strobe.
- Checks the address range, rejects malformed requests, and supports abort on interrupt (jisr).

Parameters:
- ADDR_W, 27, width of the LPDDR2 word address. Core addresses at or above 2^ADDR_W fault.
- RD_LAT, 4, cycles lpddr2_rreq is held before read data is valid (>=1).
- WR_LAT, 2, cycles lpddr2_wreq is held to commit a write (>=1).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- core_start  in  1  one-cycle request strobe, sampled only in IDLE
- core_rd  in  1  request is a read (valid with core_start)
- core_wr  in  1  request is a write (valid with core_start)
- core_addr  in  30  word address (byte address [31:2])
- core_wdata  in  32  write data
- abort  in  1  cancel an in-flight access (driven from jisr)
- core_rdata  out  32  last captured read word
- core_busy  out  1  high whenever state != IDLE
- core_done  out  1  one-cycle completion pulse
- core_fault  out  1  one-cycle rejection pulse
- lpddr2_address  out  ADDR_W  latched word address
- lpddr2_write_data  out  32  latched write data
- lpddr2_read_data  in  32  read data from LPDDR2
- lpddr2_rreq  out  1  read request level
- lpddr2_wreq  out  1  write request level

Behaviour:
- Reset: state IDLE. All outputs 0, including core_rdata, lpddr2_address and lpddr2_write_data. Latency counter 0.
- States: IDLE, RD_WAIT, WR_WAIT, DONE. core_busy = (state != IDLE).
- IDLE, core_start=1 and abort=0, evaluated in priority order:
  - core_rd=1 and core_wr=1: core_fault pulses next cycle, stay IDLE, no LPDDR2 request.
  - core_addr[29:ADDR_W] != 0: core_fault pulses next cycle, stay IDLE.
  - Neither core_rd nor core_wr (nop): go to DONE, no request.
  - core_rd: latch lpddr2_address = core_addr[ADDR_W-1:0]. lpddr2_rreq=1, counter=RD_LAT-1, go to RD_WAIT.
  - core_wr: latch address and lpddr2_write_data = core_wdata. lpddr2_wreq=1, counter=WR_LAT-1, go to WR_WAIT.
- IDLE with abort=1: core_start is ignored.
- RD_WAIT:
  - counter != 0: decrement.
  - counter == 0: core_rdata <= lpddr2_read_data, lpddr2_rreq <= 0, go to DONE.
  - lpddr2_rreq is high for exactly RD_LAT cycles.
- WR_WAIT: same as RD_WAIT with WR_LAT and lpddr2_wreq; core_rdata unchanged.
- DONE: core_done=1 for exactly one cycle, then IDLE.
- Latency: with start sampled at edge 0, core_done is high in cycle RD_LAT+1 (read) or WR_LAT+1 (write), and in cycle 1 for a nop.
- core_start while busy: ignored, not queued.
- abort in RD_WAIT or WR_WAIT: next edge drops rreq/wreq and returns to IDLE. No core_done, core_rdata unchanged, latched address/data held.
- abort in DONE: core_done still completes; the access was already committed.
- lpddr2_rreq and lpddr2_wreq are never high simultaneously.
- lpddr2_address and lpddr2_write_data change only on acceptance of a new request.
- Reset mid-access: immediate, asynchronous return to the reset state; requests deassert without waiting for an edge.
- Back-to-back: a new core_start is accepted in the first IDLE cycle after DONE, so the minimum read-to-read spacing is RD_LAT+2 cycles.

Test Plan:
- Read, addr=0x0000123, lpddr2_read_data=0xDEADBEEF in last rreq cycle -> rreq high 4 cycles, address 0x0000123, done in cycle 5, core_rdata=0xDEADBEEF.
- Write, addr=0x10, wdata=0xCAFEF00D -> wreq high 2 cycles with write_data 0xCAFEF00D, done in cycle 3, rreq never high, core_rdata unchanged.
- core_start with core_rd=core_wr=1, and separately addr=0x0800_0000 read -> core_fault one cycle, no rreq/wreq, busy stays 0, no done.
- Read started, abort in cycle 2 -> rreq low from cycle 3, state IDLE, no done, core_rdata retains previous value 0xDEADBEEF.
- Second core_start while RD_WAIT (addr 0x55) -> ignored; lpddr2_address stays 0x123, exactly one done.
- rst asserted mid WR_WAIT between edges -> wreq and busy drop immediately; all outputs 0; next read after release behaves as the first scenario.
